pe_result_buffer: RTL and testbench

- Parametrised successor to the per-PE output shift register in the systolic matmul array.
- Captures DEPTH result elements of WIDTH bits per PE. In shift mode it behaves as a plain shift chain; in multi-pass mode it accumulates partial sums across K-tiles through a recirculating ring.
- After the final pass it drains the elements serially over a valid/ready stream to the writeback path, and keeps the parallel view for debug/legacy taps.

---
 rtl/pe_result_buffer.sv | 118 +++++++++++
 tb/tb_pe_result_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_buffer.sv
`default_nettype none
// ============================================================================
// Module  : pe_result_buffer
// Brief   : Per-PE result ring: shift/accumulate across K-tiles, serial drain.
// Revision: 1.0
// ============================================================================
module pe_result_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [WIDTH-1:0]             c_i,
  input  logic                         valid_i,
  input  logic                         first_pass_i,
  input  logic                         last_pass_i,
  output logic                         in_ready_o,
  output logic [DEPTH-1:0][WIDTH-1:0]  product_o,
  output logic [WIDTH-1:0]             out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         out_last_o,
  output logic                         overflow_o
);

  localparam int c_cnt_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(DEPTH - 1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] r_product;
  logic [c_cnt_w-1:0]          r_cnt;
  logic [c_cnt_w-1:0]          r_rd_idx;
  logic                        r_overflow;

  logic                        w_accept;
  logic                        w_handshake;
  logic                        w_fill_done;
  logic                        w_drain_done;
  logic [WIDTH:0]              w_sum;
  logic                        w_sat_hi;
  logic                        w_sat_lo;
  logic                        w_clamp;
  logic [WIDTH-1:0]            w_sat_val;
  logic [WIDTH-1:0]            w_new_elem;

  assign w_accept     = valid_i && (r_state == FILL);
  assign w_handshake  = (r_state == DRAIN) && out_ready_i;
  assign w_fill_done  = w_accept && (r_cnt == c_last_idx) && last_pass_i;
  assign w_drain_done = w_handshake && (r_rd_idx == '0);

  // Sign-extended add: the top two bits disagree exactly when the result overflows.
  assign w_sum      = {c_i[WIDTH-1], c_i} + {r_product[DEPTH-1][WIDTH-1], r_product[DEPTH-1]};
  assign w_sat_hi   = ~w_sum[WIDTH] &  w_sum[WIDTH-1];
  assign w_sat_lo   =  w_sum[WIDTH] & ~w_sum[WIDTH-1];
  assign w_sat_val  = w_sat_hi ? {1'b0, {(WIDTH-1){1'b1}}} :
                      w_sat_lo ? {1'b1, {(WIDTH-1){1'b0}}} : w_sum[WIDTH-1:0];
  assign w_new_elem = first_pass_i ? c_i : w_sat_val;
  assign w_clamp    = w_accept && !first_pass_i && (w_sat_hi || w_sat_lo);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_fill_done)  w_state_nxt = DRAIN;
      DRAIN:   if (w_drain_done) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  // The oldest entry feeds the adder, so each element meets its own partial sum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_product  <= '0;
      r_cnt      <= '0;
      r_rd_idx   <= c_last_idx;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_product <= {r_product[DEPTH-2:0], w_new_elem};
        r_cnt     <= (r_cnt == c_last_idx) ? '0 : r_cnt + c_cnt_w'(1);
      end

      if (w_fill_done || w_drain_done) begin
        r_rd_idx <= c_last_idx;
      end else if (w_handshake) begin
        r_rd_idx <= r_rd_idx - c_cnt_w'(1);
      end

      if (w_drain_done) begin
        r_overflow <= 1'b0;
      end else if (w_clamp) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign in_ready_o  = (r_state == FILL);
  assign out_valid_o = (r_state == DRAIN);
  assign out_data_o  = (r_state == DRAIN) ? r_product[r_rd_idx] : '0;
  assign out_last_o  = (r_state == DRAIN) && (r_rd_idx == '0);
  assign product_o   = r_product;
  assign overflow_o  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pe_result_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pe_result_buffer
// Brief   : Directed self-checking bench for pe_result_buffer (WIDTH=16, DEPTH=4).
// Revision: 1.0
// ============================================================================
module tb_pe_result_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic                        clk_i = 1'b0;
  logic                        rst_i;
  logic [WIDTH-1:0]            c_i;
  logic                        valid_i;
  logic                        first_pass_i;
  logic                        last_pass_i;
  logic                        in_ready_o;
  logic [DEPTH-1:0][WIDTH-1:0] product_o;
  logic [WIDTH-1:0]            out_data_o;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic                        out_last_o;
  logic                        overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  pe_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .c_i          (c_i),
    .valid_i      (valid_i),
    .first_pass_i (first_pass_i),
    .last_pass_i  (last_pass_i),
    .in_ready_o   (in_ready_o),
    .product_o    (product_o),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_last_o   (out_last_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] v, input logic f, input logic l);
    c_i          = v;
    first_pass_i = f;
    last_pass_i  = l;
    valid_i      = 1'b1;
    tick();
    valid_i      = 1'b0;
  endtask

  task automatic drain4(input string tag, input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                        input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3, input logic ovf);
    logic [WIDTH-1:0] exp_d [4];
    exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_valid"}, out_valid_o, 1'b1);
      check({tag, "_data"},  out_data_o,  exp_d[i]);
      check({tag, "_last"},  out_last_o,  (i == 3));
      check({tag, "_ovf"},   overflow_o,  ovf);
      tick();
    end
    out_ready_i = 1'b0;
    check({tag, "_end_valid"}, out_valid_o, 1'b0);
    check({tag, "_end_ready"}, in_ready_o,  1'b1);
    check({tag, "_end_ovf"},   overflow_o,  1'b0);
  endtask

  initial begin
    rst_i        = 1'b1;
    c_i          = '0;
    valid_i      = 1'b0;
    first_pass_i = 1'b0;
    last_pass_i  = 1'b0;
    out_ready_i  = 1'b0;
    tick();
    check("rst_product", product_o, '0);
    check("rst_valid",   out_valid_o, 1'b0);
    check("rst_last",    out_last_o, 1'b0);
    check("rst_data",    out_data_o, '0);
    check("rst_ovf",     overflow_o, 1'b0);
    check("rst_ready",   in_ready_o, 1'b1);
    rst_i = 1'b0;
    tick();

    // Single pass behaves as a shift chain
    send_beat(16'd1, 1'b1, 1'b1);
    send_beat(16'd2, 1'b1, 1'b1);
    send_beat(16'd3, 1'b1, 1'b1);
    check("s1_ready_mid", in_ready_o, 1'b1);
    send_beat(16'd4, 1'b1, 1'b1);
    check("s1_p0", product_o[0], 16'd4);
    check("s1_p1", product_o[1], 16'd3);
    check("s1_p2", product_o[2], 16'd2);
    check("s1_p3", product_o[3], 16'd1);
    check("s1_ready_drain", in_ready_o, 1'b0);
    drain4("s1", 16'd1, 16'd2, 16'd3, 16'd4, 1'b0);

    // Two-pass accumulation
    send_beat(16'd1, 1'b1, 1'b0);
    send_beat(16'd2, 1'b1, 1'b0);
    send_beat(16'd3, 1'b1, 1'b0);
    send_beat(16'd4, 1'b1, 1'b0);
    check("s2_no_drain_valid", out_valid_o, 1'b0);
    check("s2_no_drain_ready", in_ready_o, 1'b1);
    send_beat(16'd10, 1'b0, 1'b1);
    send_beat(16'd20, 1'b0, 1'b1);
    send_beat(16'd30, 1'b0, 1'b1);
    send_beat(16'd40, 1'b0, 1'b1);
    drain4("s2", 16'd11, 16'd22, 16'd33, 16'd44, 1'b0);

    // Saturation, both rails
    send_beat(16'h7FF0, 1'b1, 1'b0);
    send_beat(16'h8000, 1'b1, 1'b0);
    send_beat(16'h0005, 1'b1, 1'b0);
    send_beat(16'h0000, 1'b1, 1'b0);
    check("s3_ovf_pre", overflow_o, 1'b0);
    send_beat(16'h0020, 1'b0, 1'b1);
    check("s3_ovf_hi", overflow_o, 1'b1);
    send_beat(16'hFFFF, 1'b0, 1'b1);
    send_beat(16'hFFFE, 1'b0, 1'b1);
    send_beat(16'h0000, 1'b0, 1'b1);
    drain4("s3", 16'h7FFF, 16'h8000, 16'h0003, 16'h0000, 1'b1);

    // Backpressure on the second drain beat, input ignored while draining
    send_beat(16'd1, 1'b1, 1'b1);
    send_beat(16'd2, 1'b1, 1'b1);
    send_beat(16'd3, 1'b1, 1'b1);
    send_beat(16'd4, 1'b1, 1'b1);
    out_ready_i = 1'b1;
    check("s4_d0", out_data_o, 16'd1);
    tick();
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      c_i = 16'h0063; first_pass_i = 1'b1; last_pass_i = 1'b1; valid_i = 1'b1;
      check("s4_hold_valid", out_valid_o, 1'b1);
      check("s4_hold_data",  out_data_o,  16'd2);
      check("s4_hold_last",  out_last_o,  1'b0);
      check("s4_hold_ready", in_ready_o,  1'b0);
      tick();
    end
    valid_i = 1'b0;
    check("s4_p0_kept", product_o[0], 16'd4);
    check("s4_p3_kept", product_o[3], 16'd1);
    out_ready_i = 1'b1;
    check("s4_d1", out_data_o, 16'd2);
    tick();
    check("s4_d2", out_data_o, 16'd3);
    tick();
    check("s4_d3", out_data_o, 16'd4);
    check("s4_d3_last", out_last_o, 1'b1);
    // Beat offered alongside the final handshake must wait a cycle
    c_i = 16'd77; first_pass_i = 1'b1; last_pass_i = 1'b0; valid_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("s4_simul_valid", out_valid_o, 1'b0);
    check("s4_simul_p0",    product_o[0], 16'd4);
    check("s4_simul_ready", in_ready_o, 1'b1);
    tick();
    valid_i = 1'b0;
    check("s4_next_p0", product_o[0], 16'd77);
    send_beat(16'd0, 1'b1, 1'b0);
    send_beat(16'd0, 1'b1, 1'b0);
    send_beat(16'd0, 1'b1, 1'b0);
    check("s4_realign_ready", in_ready_o, 1'b1);

    // Gapped input
    for (int b = 1; b <= 4; b++) begin
      send_beat(WIDTH'(b), 1'b1, 1'b1);
      if (b < 4) begin
        tick();
        tick();
        check("s5_gap_ready", in_ready_o, 1'b1);
        check("s5_gap_p0", product_o[0], WIDTH'(b));
      end
    end
    check("s5_p3", product_o[3], 16'd1);
    drain4("s5", 16'd1, 16'd2, 16'd3, 16'd4, 1'b0);

    // Asynchronous reset in the middle of a drain
    for (int b = 0; b < 4; b++) send_beat(16'h7FFF, 1'b1, 1'b0);
    for (int b = 0; b < 4; b++) send_beat(16'h0001, 1'b0, 1'b1);
    check("s6_ovf_set", overflow_o, 1'b1);
    out_ready_i = 1'b1;
    tick();
    tick();
    out_ready_i = 1'b0;
    check("s6_mid_valid", out_valid_o, 1'b1);
    check("s6_mid_data",  out_data_o,  16'h7FFF);
    #2;
    rst_i = 1'b1;
    #1;
    check("s6_rst_product", product_o, '0);
    check("s6_rst_valid",   out_valid_o, 1'b0);
    check("s6_rst_last",    out_last_o, 1'b0);
    check("s6_rst_data",    out_data_o, '0);
    check("s6_rst_ovf",     overflow_o, 1'b0);
    check("s6_rst_ready",   in_ready_o, 1'b1);
    tick();
    rst_i = 1'b0;
    send_beat(16'd5, 1'b1, 1'b1);
    send_beat(16'd6, 1'b1, 1'b1);
    send_beat(16'd7, 1'b1, 1'b1);
    send_beat(16'd8, 1'b1, 1'b1);
    drain4("s6", 16'd5, 16'd6, 16'd7, 16'd8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
